stim_gen_param: RTL and testbench

Parametrised, synthesizable stimulus generator for the pipelined adder datapaths (sumador family).
- Drives NCH channels of WIDTH-bit operands with a programmable sequence: increment, decrement, LFSR or hold.
- Runs for a programmable number of transfers and hands data to the DUT over a valid/ready handshake.
- Sits between the test harness control and the DUT operand inputs. Signals completion with a one-cycle done pulse.

---
 rtl/stim_gen_param_pkg.sv | 27 ++
 rtl/stim_gen_param_lane.sv | 57 +++++
 rtl/stim_gen_param.sv | 140 ++++++++++++++
 tb/tb_stim_gen_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stim_gen_param_pkg.sv
// -----------------------------------------------------------------------------
// stim_pkg
// Shared definitions for the stimulus generator: mode encoding, FSM state
// encoding and the per-lane control bundle passed from the top to each lane.
// -----------------------------------------------------------------------------
package stim_pkg;

  // Sequence modes as seen on the 'mode' port
  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_DEC  = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control shared by every lane in a given cycle
  typedef struct packed {
    logic       load;  // load init value (start accepted)
    logic       adv;   // advance to next value (transfer)
    logic [1:0] mode;  // mode used for load guard / advance rule
  } lane_ctl_t;

endpackage

// File: rtl/stim_gen_param_lane.sv
// -----------------------------------------------------------------------------
// stim_lane
// One operand channel: WIDTH-bit value register plus its next-value logic.
//   clk, reset : clock, synchronous active-high reset
//   i_ctl      : load / advance strobes and the mode to apply
//   i_init     : value loaded on i_ctl.load
//   i_step     : increment/decrement amount (captured copy from the top)
//   o_val      : current channel value (registered)
// -----------------------------------------------------------------------------
module stim_lane
  import stim_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 'hC
) (
  input  logic             clk,
  input  logic             reset,
  input  lane_ctl_t        i_ctl,
  input  logic [WIDTH-1:0] i_init,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_val
);

  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;

  // An all-zero LFSR state never leaves zero, so seed it with 1 instead.
  always_comb begin
    w_load_val = i_init;
    if (i_ctl.mode == MODE_LFSR && i_init == '0)
      w_load_val = WIDTH'(1);
  end

  // Next-value rules; arithmetic wraps modulo 2^WIDTH by truncation.
  always_comb begin
    w_next = r_val;
    case (i_ctl.mode)
      MODE_INC:  w_next = r_val + i_step;
      MODE_DEC:  w_next = r_val - i_step;
      MODE_LFSR: w_next = (r_val >> 1) ^ (r_val[0] ? TAPS : '0);
      default:   w_next = r_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_val <= '0;
    else if (i_ctl.load)
      r_val <= w_load_val;
    else if (i_ctl.adv)
      r_val <= w_next;
  end

  assign o_val = r_val;

endmodule

// File: rtl/stim_gen_param.sv
// -----------------------------------------------------------------------------
// stim_gen_param
// Stimulus generator for the pipelined adder datapaths. Drives NCH channels of
// WIDTH-bit operands through a valid/ready handshake for a programmed number of
// transfers, then pulses done for one cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a sequence (IDLE only)
//   abort        : cancel a running sequence (RUN only)
//   mode/step    : sequence rule and step, captured at start
//   length       : number of transfers, captured at start
//   init_vals    : per-channel seed, channel i at [i*WIDTH +: WIDTH]
//   out_ready    : DUT accepts data
//   out_valid    : data_out valid (RUN)
//   data_out     : channel operands, same packing as init_vals
//   count        : transfers completed in the current sequence
//   busy         : high in RUN
//   done         : one-cycle completion pulse
// All outputs come straight from registers or from decoded state.
// -----------------------------------------------------------------------------
module stim_gen_param
  import stim_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               NCH   = 2,
  parameter int               LEN_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = 'hC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     step,
  input  logic [LEN_W-1:0]     length,
  input  logic [NCH*WIDTH-1:0] init_vals,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [LEN_W-1:0]     count,
  output logic                 busy,
  output logic                 done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_step;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;

  logic      w_start;
  logic      w_xfer;
  logic      w_last;
  lane_ctl_t w_ctl;

  logic [NCH-1:0][WIDTH-1:0] w_init;
  logic [NCH-1:0][WIDTH-1:0] w_lane;

  assign w_start = (r_state == IDLE) && start;
  assign w_xfer  = (r_state == RUN) && out_ready;
  // The transfer that brings count up to the captured length ends the run.
  assign w_last  = w_xfer && ((r_count + LEN_W'(1)) == r_len);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------- next state
  // Abort beats completion: an aborted run never reports done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = (length == '0) ? DONE : RUN;
      RUN: begin
        if (abort)       w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    out_valid = (r_state == RUN);
    busy      = (r_state == RUN);
    done      = (r_state == DONE);
  end

  // ------------------------------------------------- captured config + count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode  <= MODE_INC;
      r_step  <= '0;
      r_len   <= '0;
      r_count <= '0;
    end else if (w_start) begin
      r_mode  <= mode;
      r_step  <= step;
      r_len   <= length;
      r_count <= '0;
    end else if (w_xfer) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

  assign count = r_count;

  // -------------------------------------------------------------------- lanes
  // On load the live mode decides the LFSR zero guard (it is being captured in
  // the same cycle); afterwards lanes follow the captured mode.
  always_comb begin
    w_ctl.load = w_start;
    w_ctl.adv  = w_xfer;
    w_ctl.mode = w_start ? mode : r_mode;
  end

  assign w_init = init_vals;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    stim_lane #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_ctl  (w_ctl),
      .i_init (w_init[g]),
      .i_step (r_step),
      .o_val  (w_lane[g])
    );
  end

  assign data_out = w_lane;

endmodule

// File: tb/tb_stim_gen_param.sv
module tb_stim_gen_param;
  localparam int             W   = 4;
  localparam int             NCH = 2;
  localparam int             LW  = 8;
  localparam logic [W-1:0]   TP  = 4'hC;
  localparam int             MAXCYC = 600;

  logic              clk = 1'b0;
  logic              reset, start, abort, out_ready;
  logic [1:0]        mode;
  logic [W-1:0]      step;
  logic [LW-1:0]     length;
  logic [NCH*W-1:0]  init_vals;
  logic              out_valid, busy, done;
  logic [NCH*W-1:0]  data_out;
  logic [LW-1:0]     count;

  int total = 0;
  int bad   = 0;

  // Reference model: phase (0 idle, 1 streaming, 2 done pulse), transfers so far
  // and the captured sequence parameters. Data is computed in closed form.
  int               m_ph, m_n, m_len, m_mode, m_step;
  logic [NCH*W-1:0] m_init;
  bit               m_loaded;

  stim_gen_param #(.WIDTH(W), .NCH(NCH), .LEN_W(LW), .TAPS(TP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .step(step), .length(length), .init_vals(init_vals), .out_ready(out_ready),
    .out_valid(out_valid), .data_out(data_out), .count(count), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Value of one channel after n transfers from seed v0.
  function automatic logic [W-1:0] ref_val(int md, int stp, logic [W-1:0] v0, int n);
    int v;
    v = int'(v0);
    case (md)
      0: v = v + n * stp;
      1: v = v - n * stp;
      2: begin
        if (v == 0) v = 1;
        for (int k = 0; k < n; k++) v = (v >> 1) ^ ((v % 2 == 1) ? int'(TP) : 0);
      end
      default: ;
    endcase
    return v[W-1:0];
  endfunction

  function automatic logic [NCH*W-1:0] ref_data();
    logic [NCH*W-1:0] d;
    d = '0;
    if (m_loaded)
      for (int c = 0; c < NCH; c++)
        d[c*W +: W] = ref_val(m_mode, m_step, m_init[c*W +: W], m_n);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_ph == 1));
    chk({tag, ".busy"},  64'(busy),      64'(m_ph == 1));
    chk({tag, ".done"},  64'(done),      64'(m_ph == 2));
    chk({tag, ".count"}, 64'(count),     64'(m_n));
    chk({tag, ".data"},  64'(data_out),  64'(ref_data()));
  endtask

  // Idle cycles with noise on every input; abort outside RUN must do nothing.
  task automatic idle_cycles(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      start = 1'b0; abort = 1'b1; out_ready = 1'($urandom);
      mode = 2'($urandom); step = W'($urandom); length = LW'($urandom);
      init_vals = (NCH*W)'($urandom);
      @(negedge clk);
      check_outs(tag);
    end
    abort = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stall on 2nd and 3rd RUN cycles.
  // abort_at: abort together with transfer number abort_at (0 = never).
  // reset_at: raise reset (with start) once this many transfers are done.
  task automatic run_seq(input string tag, input int md, input int stp, input int len,
                         input logic [NCH*W-1:0] iv, input int rmode,
                         input int abort_at, input int reset_at);
    int  cyc, rc;
    bit  rdy, ab;
    mode = 2'(md); step = W'(stp); length = LW'(len); init_vals = iv;
    start = 1'b1; abort = 1'($urandom);   // start beats abort in IDLE
    out_ready = 1'($urandom);
    m_mode = md; m_step = stp; m_len = len; m_init = iv;
    m_n = 0; m_loaded = 1; m_ph = (len == 0) ? 2 : 1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cyc = 0; rc = 0;
    while (m_ph != 0 && cyc < MAXCYC) begin
      check_outs(tag);
      // Port changes after start must not matter.
      mode = 2'($urandom); step = W'($urandom); length = LW'($urandom);
      init_vals = (NCH*W)'($urandom); start = 1'($urandom);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(rc == 1 || rc == 2);
      endcase
      ab = (m_ph == 1 && abort_at > 0 && m_n == abort_at - 1);
      if (ab) rdy = 1'b1;
      out_ready = rdy;
      abort = ab || (m_ph == 2 && $urandom_range(0, 1) == 1);
      if (m_ph == 1 && reset_at > 0 && m_n == reset_at) begin
        reset = 1'b1; start = 1'b1;
        m_ph = 0; m_n = 0; m_loaded = 0;
      end else if (m_ph == 1) begin
        rc++;
        if (rdy) m_n++;
        if (ab) m_ph = 0;
        else if (m_n == m_len) m_ph = 2;
      end else begin
        m_ph = 0;
      end
      @(negedge clk);
      cyc++;
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    chk({tag, ".bound"}, 64'(cyc < MAXCYC), 64'(1));
    check_outs({tag, ".end"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    mode = '0; step = '0; length = '0; init_vals = '0;
    m_ph = 0; m_n = 0; m_len = 0; m_mode = 0; m_step = 0; m_init = '0; m_loaded = 0;
    repeat (2) @(negedge clk);
    check_outs("reset");
    reset = 1'b0;
    idle_cycles("idle0", 2);

    run_seq("t1_inc", 0, 1, 7, {4'd15, 4'd0}, 0, 0, 0);
    chk("t1_count7", 64'(count), 64'(7));
    idle_cycles("idle1", 1);
    run_seq("t2_stall", 0, 1, 7, {4'd15, 4'd0}, 2, 0, 0);
    chk("t2_count7", 64'(count), 64'(7));
    run_seq("t3_dec", 1, 3, 3, {4'd0, 4'd2}, 0, 0, 0);
    run_seq("t4_lfsr", 2, 0, 4, {4'd1, 4'd0}, 0, 0, 0);
    chk("t4_last_ch0", 64'(data_out[3:0]), 64'(4'hD));
    run_seq("t5_len0", 0, 1, 0, {4'd5, 4'd9}, 0, 0, 0);
    chk("t5_count0", 64'(count), 64'(0));
    run_seq("t6_abort", 0, 2, 10, {4'd3, 4'd7}, 1, 4, 0);
    chk("t6_count4", 64'(count), 64'(4));
    idle_cycles("idle6", 2);
    run_seq("t6_reset", 1, 1, 10, {4'd8, 4'd4}, 0, 0, 3);
    idle_cycles("after_rst", 2);
    run_seq("hold", 3, 5, 5, (NCH*W)'($urandom), 1, 0, 0);
    run_seq("long", 0, 7, 255, (NCH*W)'($urandom), 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int len, ab_at;
      len   = $urandom_range(0, 12);
      ab_at = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
      run_seq("rand", $urandom_range(0, 3), $urandom_range(0, 15), len,
              (NCH*W)'($urandom), 1, ab_at, 0);
      idle_cycles("rand_idle", $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
